// File: rtl/parity_mem_pkg.sv
// rtl/parity_mem_pkg.sv - shared types and helpers for the parity memory controller
package parity_mem_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CHECK,
    ST_RESP
  } state_e;

  // Requester identifiers, also the encoding of the round-robin LAST pointer
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // Even parity over one data byte
  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/pmc_rr_arb.sv
// rtl/pmc_rr_arb.sv - two-way round-robin arbiter with LAST pointer
module pmc_rr_arb
  import parity_mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_a_i,
  input  logic       req_b_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // Pick a winner when enabled; a tie goes to the requester not served last
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      if (req_a_i && req_b_i) begin
        gnt_o = (last_q == ID_B) ? 2'b01 : 2'b10;
      end else if (req_a_i) begin
        gnt_o = 2'b01;
      end else if (req_b_i) begin
        gnt_o = 2'b10;
      end
      if (gnt_o[0]) begin
        last_d = ID_A;
      end else if (gnt_o[1]) begin
        last_d = ID_B;
      end
    end
  end

  // LAST starts at B so that A wins the first tie after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= ID_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/parity_mem_ctrl.sv
// rtl/parity_mem_ctrl.sv - arbitrated sequencer for the parity-protected byte memory
module parity_mem_ctrl
  import parity_mem_pkg::*;
#(
  parameter int AW        = 4,
  parameter int MAX_RETRY = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_req_i,
  input  logic             a_we_i,
  input  logic [AW-1:0]    a_addr_i,
  input  logic [7:0]       a_wdata_i,
  output logic             a_ack_o,
  output logic [7:0]       a_rdata_o,
  output logic             a_perr_o,
  input  logic             b_req_i,
  input  logic             b_we_i,
  input  logic [AW-1:0]    b_addr_i,
  input  logic [7:0]       b_wdata_i,
  output logic             b_ack_o,
  output logic [7:0]       b_rdata_o,
  output logic             b_perr_o,
  output logic             mem_rd_o,
  output logic             mem_wr_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [7:0]       mem_din_o,
  output logic             mem_pin_o,
  input  logic [7:0]       mem_dout_i,
  input  logic             mem_pout_i,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] err_cnt_o
);

  // Retry counter needs at least one bit even when retry is disabled
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  state_e           state_q;
  logic             gnt_id_q;
  logic [RW-1:0]    retry_q;
  logic             a_ack_q, b_ack_q;
  logic             a_perr_q, b_perr_q;
  logic [7:0]       a_rdata_q, b_rdata_q;
  logic             mem_rd_q, mem_wr_q, mem_pin_q;
  logic [AW-1:0]    mem_addr_q;
  logic [7:0]       mem_din_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic [1:0]       gnt;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [7:0]       sel_wdata;
  logic             rd_err;

  pmc_rr_arb u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_a_i (a_req_i),
    .req_b_i (b_req_i),
    .en_i    (state_q == ST_IDLE),
    .gnt_o   (gnt)
  );

  // Operands of whichever requester wins this cycle
  assign sel_we    = gnt[1] ? b_we_i    : a_we_i;
  assign sel_addr  = gnt[1] ? b_addr_i  : a_addr_i;
  assign sel_wdata = gnt[1] ? b_wdata_i : a_wdata_i;

  // Stored byte plus stored parity must have even weight
  assign rd_err = parity8(mem_dout_i) ^ mem_pout_i;

  // Sequencer: grant and capture, strobe memory, check/retry reads, respond, count errors
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gnt_id_q   <= ID_A;
      retry_q    <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_perr_q   <= 1'b0;
      b_perr_q   <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_pin_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            gnt_id_q   <= gnt[1] ? ID_B : ID_A;
            mem_addr_q <= sel_addr;
            mem_din_q  <= sel_wdata;
            mem_pin_q  <= parity8(sel_wdata);
            if (sel_we) begin
              mem_wr_q <= 1'b1;
              state_q  <= ST_WRITE;
            end else begin
              mem_rd_q <= 1'b1;
              state_q  <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          mem_wr_q <= 1'b0;
          if (gnt_id_q == ID_B) b_ack_q <= 1'b1;
          else                  a_ack_q <= 1'b1;
          state_q <= ST_RESP;
        end
        ST_READ: begin
          mem_rd_q <= 1'b0;
          state_q  <= ST_CHECK;
        end
        ST_CHECK: begin
          if (rd_err && (retry_q < RETRY_LIMIT)) begin
            retry_q  <= retry_q + RW'(1);
            mem_rd_q <= 1'b1;
            state_q  <= ST_READ;
          end else begin
            if (gnt_id_q == ID_B) begin
              b_ack_q   <= 1'b1;
              b_rdata_q <= mem_dout_i;
              b_perr_q  <= rd_err;
            end else begin
              a_ack_q   <= 1'b1;
              a_rdata_q <= mem_dout_i;
              a_perr_q  <= rd_err;
            end
            if (rd_err && (err_cnt_q != '1)) begin
              err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          retry_q <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // A clear overrides a same-cycle increment
      if (err_clr_i) begin
        err_cnt_q <= '0;
      end
    end
  end

  assign a_ack_o    = a_ack_q;
  assign b_ack_o    = b_ack_q;
  assign a_rdata_o  = a_rdata_q;
  assign b_rdata_o  = b_rdata_q;
  assign a_perr_o   = a_perr_q;
  assign b_perr_o   = b_perr_q;
  assign mem_rd_o   = mem_rd_q;
  assign mem_wr_o   = mem_wr_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_din_o  = mem_din_q;
  assign mem_pin_o  = mem_pin_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_parity_mem_ctrl.sv
// tb/tb_parity_mem_ctrl.sv - directed and random checks of parity_mem_ctrl
module tb_parity_mem_ctrl;

  localparam int AW = 4;
  localparam int MAX_RETRY = 1;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic a_ack, b_ack, a_perr, b_perr;
  logic [7:0] a_rdata, b_rdata;
  logic mem_rd, mem_wr, mem_pin;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout = '0;
  logic mem_pout = 1'b0;
  logic err_clr = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  int passed = 0;
  int total = 0;

  logic [8:0] mem [16] = '{default: '0};
  int rd_total = 0;
  int corrupt_idx = -1;
  bit corrupt_all = 1'b0;
  int overlap = 0;
  int a_acks = 0;
  int b_acks = 0;
  logic [7:0] sb [16];

  parity_mem_ctrl #(.AW(AW), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_ack_o(a_ack), .a_rdata_o(a_rdata), .a_perr_o(a_perr),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_ack_o(b_ack), .b_rdata_o(b_rdata), .b_perr_o(b_perr),
    .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_din_o(mem_din), .mem_pin_o(mem_pin),
    .mem_dout_i(mem_dout), .mem_pout_i(mem_pout),
    .err_clr_i(err_clr), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: stores data+parity, returns read data one cycle after MEM_RD, optionally flips parity
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= {mem_pin, mem_din};
    if (mem_rd) begin
      mem_dout <= mem[mem_addr][7:0];
      mem_pout <= mem[mem_addr][8] ^ (corrupt_all || (rd_total == corrupt_idx));
      rd_total <= rd_total + 1;
    end
  end

  // Bus monitor
  always @(negedge clk) begin
    if (mem_rd && mem_wr) overlap <= overlap + 1;
    if (a_ack) a_acks <= a_acks + 1;
    if (b_ack) b_acks <= b_acks + 1;
  end

  task automatic xfer(input bit port, input bit we, input logic [3:0] addr, input logic [7:0] wd,
                      output int lat, output logic [7:0] rd, output logic pe);
    lat = -1; rd = '0; pe = 1'b0;
    if (!port) begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
    else       begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!port && a_ack) begin lat = c; rd = a_rdata; pe = a_perr; break; end
      if (port && b_ack)  begin lat = c; rd = b_rdata; pe = b_perr; break; end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      total++;
      $display("FAIL xfer_timeout port=%0d addr=%0d: no ACK within 60 cycles", port, addr);
    end
    @(posedge clk); #1;
    if (!port) a_req = 1'b0; else b_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if ({a_ack, b_ack, a_perr, b_perr} !== 4'b0) $display("FAIL reset_ack_perr got=%b exp=0000", {a_ack, b_ack, a_perr, b_perr}); else passed++;
    total++; if ({a_rdata, b_rdata} !== 16'h0) $display("FAIL reset_rdata got=%h exp=0000", {a_rdata, b_rdata}); else passed++;
    total++; if ({mem_rd, mem_wr, mem_pin} !== 3'b0) $display("FAIL reset_strobes got=%b exp=000", {mem_rd, mem_wr, mem_pin}); else passed++;
    total++; if ({mem_addr, mem_din} !== 12'h0) $display("FAIL reset_mem_bus got=%h exp=000", {mem_addr, mem_din}); else passed++;
    total++; if (err_cnt !== 2'd0) $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_tie(input int k, input bit a_first);
    int a_at, b_at;
    a_at = -1; b_at = -1;
    a_we = 1'b1; a_addr = 4'(k); a_wdata = 8'(8'h10 + k);
    b_we = 1'b1; b_addr = 4'(k + 8); b_wdata = 8'(8'h20 + k);
    a_req = 1'b1; b_req = 1'b1;
    for (int c = 0; c < 40 && (a_at < 0 || b_at < 0); c++) begin
      @(negedge clk);
      if (a_ack && a_at < 0) a_at = c;
      if (b_ack && b_at < 0) b_at = c;
      @(posedge clk); #1;
      if (a_at >= 0) a_req = 1'b0;
      if (b_at >= 0) b_req = 1'b0;
    end
    a_req = 1'b0; b_req = 1'b0;
    total++; if (a_at !== (a_first ? 2 : 5)) $display("FAIL tie%0d_a_ack_cycle got=%0d exp=%0d", k, a_at, a_first ? 2 : 5); else passed++;
    total++; if (b_at !== (a_first ? 5 : 2)) $display("FAIL tie%0d_b_ack_cycle got=%0d exp=%0d", k, b_at, a_first ? 5 : 2); else passed++;
  endtask

  task automatic test_arbitration();
    int lat; logic [7:0] rd; logic pe;
    test_tie(0, 1'b1);
    test_tie(1, 1'b1);
    xfer(1'b0, 1'b1, 4'd2, 8'h33, lat, rd, pe);
    test_tie(2, 1'b0);
  endtask

  task automatic test_write_read();
    int lat; logic [7:0] rd; logic pe;
    xfer(1'b0, 1'b1, 4'd3, 8'hA5, lat, rd, pe);
    total++; if (lat !== 2) $display("FAIL wr_latency got=%0d exp=2", lat); else passed++;
    total++; if ({mem_addr, mem_din, mem_pin} !== {4'd3, 8'hA5, 1'b0}) $display("FAIL wr_bus_a5 got=%h exp=%h", {mem_addr, mem_din, mem_pin}, {4'd3, 8'hA5, 1'b0}); else passed++;
    xfer(1'b0, 1'b0, 4'd3, 8'h00, lat, rd, pe);
    total++; if (lat !== 3) $display("FAIL rd_latency got=%0d exp=3", lat); else passed++;
    total++; if ({rd, pe} !== {8'hA5, 1'b0}) $display("FAIL rd_a5 got=%h/%b exp=a5/0", rd, pe); else passed++;
    total++; if (err_cnt !== 2'd0) $display("FAIL rd_clean_err_cnt got=%0d exp=0", err_cnt); else passed++;
    xfer(1'b1, 1'b1, 4'd7, 8'h01, lat, rd, pe);
    total++; if (mem_pin !== 1'b1) $display("FAIL wr_pin_odd got=%b exp=1", mem_pin); else passed++;
    xfer(1'b1, 1'b0, 4'd7, 8'h00, lat, rd, pe);
    total++; if ({rd, pe} !== {8'h01, 1'b0}) $display("FAIL rd_b_01 got=%h/%b exp=01/0", rd, pe); else passed++;
  endtask

  task automatic test_retry();
    int lat, rd0; logic [7:0] rd; logic pe;
    rd0 = rd_total;
    corrupt_idx = rd_total;
    xfer(1'b0, 1'b0, 4'd3, 8'h00, lat, rd, pe);
    corrupt_idx = -1;
    total++; if (lat !== 5) $display("FAIL retry_latency got=%0d exp=5", lat); else passed++;
    total++; if (rd_total - rd0 !== 2) $display("FAIL retry_rd_pulses got=%0d exp=2", rd_total - rd0); else passed++;
    total++; if ({rd, pe} !== {8'hA5, 1'b0}) $display("FAIL retry_data got=%h/%b exp=a5/0", rd, pe); else passed++;
    total++; if (err_cnt !== 2'd0) $display("FAIL retry_err_cnt got=%0d exp=0", err_cnt); else passed++;
  endtask

  task automatic test_uncorrected();
    int lat; logic [7:0] rd; logic pe;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    corrupt_all = 1'b1;
    for (int i = 0; i < 5; i++) begin
      xfer(1'b1, 1'b0, 4'd7, 8'h00, lat, rd, pe);
      total++; if ({lat, rd, pe} !== {32'd5, 8'h01, 1'b1}) $display("FAIL bad_read%0d got=lat%0d %h/%b exp=lat5 01/1", i, lat, rd, pe); else passed++;
      total++; if (err_cnt !== exp_cnt[i]) $display("FAIL err_cnt_sat%0d got=%0d exp=%0d", i, err_cnt, exp_cnt[i]); else passed++;
    end
    corrupt_all = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, seen; logic [7:0] rd; logic pe;
    a_we = 1'b0; a_addr = 4'd3; a_req = 1'b1;
    @(posedge clk); #1;
    total++; if (mem_rd !== 1'b1) $display("FAIL mid_in_read got=%b exp=1", mem_rd); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({mem_rd, mem_wr, a_ack, b_ack, a_perr, b_perr} !== 6'b0) $display("FAIL mid_rst_strobes got=%b exp=000000", {mem_rd, mem_wr, a_ack, b_ack, a_perr, b_perr}); else passed++;
    total++; if ({a_rdata, b_rdata, err_cnt} !== 18'h0) $display("FAIL mid_rst_regs got=%h exp=0", {a_rdata, b_rdata, err_cnt}); else passed++;
    total++; if ({mem_addr, mem_din, mem_pin} !== 13'h0) $display("FAIL mid_rst_bus got=%h exp=0", {mem_addr, mem_din, mem_pin}); else passed++;
    a_req = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (a_ack || b_ack) seen++;
    end
    total++; if (seen !== 0) $display("FAIL mid_rst_no_ack got=%0d exp=0", seen); else passed++;
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, 4'd3, 8'h00, lat, rd, pe);
    total++; if ({lat, rd, pe} !== {32'd3, 8'hA5, 1'b0}) $display("FAIL post_rst_b_read got=lat%0d %h/%b exp=lat3 a5/0", lat, rd, pe); else passed++;
  endtask

  task automatic test_err_clr();
    int lat; logic [7:0] rd; logic pe;
    corrupt_all = 1'b1;
    xfer(1'b0, 1'b0, 4'd3, 8'h00, lat, rd, pe);
    total++; if ({err_cnt, pe} !== {2'd1, 1'b1}) $display("FAIL clr_pre got=%0d/%b exp=1/1", err_cnt, pe); else passed++;
    err_clr = 1'b1;
    xfer(1'b0, 1'b0, 4'd3, 8'h00, lat, rd, pe);
    err_clr = 1'b0;
    corrupt_all = 1'b0;
    total++; if ({err_cnt, pe} !== {2'd0, 1'b1}) $display("FAIL clr_wins got=%0d/%b exp=0/1", err_cnt, pe); else passed++;
  endtask

  task automatic rand_port(input bit port, input int n);
    int lat; logic [7:0] rd, wd; logic pe; bit we; logic [3:0] addr;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      we = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      wd = 8'($urandom);
      xfer(port, we, addr, wd, lat, rd, pe);
      if (we) sb[addr] = wd;
      else begin
        total++; if ({rd, pe} !== {sb[addr], 1'b0}) $display("FAIL rand_rd port=%0d addr=%0d got=%h/%b exp=%h/0", port, addr, rd, pe, sb[addr]); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, a0, b0; logic [7:0] rd, wd; logic pe;
    a0 = a_acks; b0 = b_acks;
    for (int i = 0; i < 16; i++) begin
      wd = 8'($urandom);
      xfer(1'b0, 1'b1, 4'(i), wd, lat, rd, pe);
      sb[i] = wd;
    end
    fork
      rand_port(1'b0, 20);
      rand_port(1'b1, 20);
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (a_acks - a0 !== 36) $display("FAIL rand_a_acks got=%0d exp=36", a_acks - a0); else passed++;
    total++; if (b_acks - b0 !== 20) $display("FAIL rand_b_acks got=%0d exp=20", b_acks - b0); else passed++;
    total++; if (overlap !== 0) $display("FAIL rd_wr_overlap got=%0d exp=0", overlap); else passed++;
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_write_read();
    test_retry();
    test_uncorrected();
    test_reset_mid();
    test_err_clr();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/parity_mem_ctrl.md
# parity_mem_ctrl

Sequencing controller and two-port round-robin arbiter for the parity-protected byte memory. It accepts read/write requests from requesters A and B and drives the memory's RD/WR strobes, address and data. It generates the stored parity bit on writes, checks data plus parity on reads, and retries failed reads. It returns read data with a per-transfer parity-error flag and keeps a saturating count of uncorrected errors.

## Interface
- AW, 4: memory address width.
- MAX_RETRY, 1: extra read attempts after a parity error; 0 disables retry.
- CNT_W, 8: error counter width.

- CLK  in  1  system clock, all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset; one clock.
- A_REQ / B_REQ  in  1  request, held until ACK.
- A_WE / B_WE  in  1  1 = write, 0 = read; stable while REQ.
- A_ADDR / B_ADDR  in  AW  address; stable while REQ.
- A_WDATA / B_WDATA  in  8  write data; stable while REQ.
- A_ACK / B_ACK  out  1  one-cycle completion pulse.
- A_RDATA / B_RDATA  out  8  read data, valid with ACK on reads.
- A_PERR / B_PERR  out  1  parity error on this read after retries, valid with ACK.
- MEM_RD  out  1  memory read strobe.
- MEM_WR  out  1  memory write strobe.
- MEM_ADDR  out  AW  memory address.
- MEM_DIN  out  8  memory write data.
- MEM_PIN  out  1  stored parity bit.
- MEM_DOUT  in  8  memory read data, valid the cycle after MEM_RD.
- MEM_POUT  in  1  stored parity, valid the cycle after MEM_RD.
- ERR_CLR  in  1  synchronous clear of ERR_CNT.
- ERR_CNT  out  CNT_W  uncorrected read errors, saturating.

## Operation
- Parity: MEM_PIN = XOR of the 8 write bits. Read error = XOR(MEM_DOUT, MEM_POUT) = 1.
- FSM states: IDLE, WRITE, READ, CHECK, RESP.
- IDLE: if any REQ is high, grant a requester, capture its WE/ADDR/WDATA into registers, then go to WRITE (WE=1) or READ (WE=0).
- Arbitration:
  - If both request, grant the one not served last.
  - The LAST pointer resets to B, so A wins the first tie.
  - LAST updates at grant.
- WRITE: MEM_WR=1 for one cycle → RESP.
- READ: MEM_RD=1 for one cycle → CHECK.
- CHECK: sample MEM_DOUT/MEM_POUT.
  - No error → RESP with PERR=0.
  - Error and retry count < MAX_RETRY → increment retry count → READ.
  - Error and retries exhausted → RESP with PERR=1, ERR_CNT+1 (saturating at all-ones).
- RESP: granted ACK=1 for one cycle with RDATA/PERR → IDLE. Retry count clears.
- RDATA/PERR hold their last value between ACKs. The ungranted port's outputs stay 0.
- MEM_RD and MEM_WR are never high together. Both are 0 outside READ/WRITE.
- MEM_ADDR/MEM_DIN/MEM_PIN are registered and hold the last captured values.
- ERR_CLR coinciding with an increment: clear wins.

## Timing
- Reset values: all ACK/PERR/RDATA, MEM_RD, MEM_WR, MEM_ADDR, MEM_DIN, MEM_PIN and ERR_CNT are 0. State = IDLE, LAST = B.
- Write latency: REQ seen in IDLE at cycle 0 → MEM_WR at cycle 1 → ACK at cycle 2.
- Read latency: MEM_RD at cycle 1 → CHECK at cycle 2 → ACK at cycle 3. Each retry adds 2 cycles.
- Requester clears REQ on the edge where it samples ACK. REQ still high in the IDLE cycle after ACK counts as a new request.
- Minimum spacing between grants: one IDLE cycle.
- A REQ arriving while busy waits; it is not lost.
- RST_N asserted mid-operation: the in-flight transfer is abandoned with no ACK. The strobes drop asynchronously.

## Structure
- Package parity_mem_pkg holds:
  - state enum
  - function parity8 (8-bit XOR)
  - ID constants for requesters A and B
- Sub-module pmc_rr_arb: 2-way round-robin arbiter (REQ pair, grant-enable, LAST register → one-hot grant).
- FSM, operand capture and error counter stay in parity_mem_ctrl.

## Test plan
- Write A addr 3 data 8'hA5, then read A addr 3 with a clean model → MEM_PIN=0 on write, ACK at cycle 3, RDATA=8'hA5, PERR=0, ERR_CNT=0.
- A and B request in the same cycle → A granted first, B granted after A's ACK. Repeated ties alternate strictly.
- MAX_RETRY=1: model corrupts the first read only → MEM_RD pulses twice, ACK at cycle 5, PERR=0, ERR_CNT unchanged.
- Model corrupts every read → PERR=1, ERR_CNT=1. With CNT_W=2 and 5 such reads, ERR_CNT saturates at 3. ERR_CLR together with an increment gives 0.
- RST_N pulsed low during READ → no ACK, all outputs 0 immediately. After release, a B request is served normally.
- Random mixed traffic on both ports with a scoreboard → every REQ gets exactly one ACK, MEM_RD and MEM_WR are never high together, and read data matches the last write per address.
